// File: rtl/sprite_draw_scheduler.sv
// Round-robin sprite draw scheduler: grants one requester and scans its sprite through
// the ROM. It then turns each returned pixel into a screen-space VGA plot write.
module sprite_draw_scheduler #(
   parameter int           NUM_REQ     = 4,
   parameter int           WIDTH_SEL   = 2,
   parameter int           SPRITE_W    = 10,
   parameter int           SPRITE_H    = 10,
   parameter int           WIDTH_SX    = 4,
   parameter int           WIDTH_SY    = 4,
   parameter int           SCREEN_W    = 160,
   parameter int           SCREEN_H    = 120,
   parameter int           WIDTH_X     = 8,
   parameter int           WIDTH_Y     = 7,
   parameter logic [2:0]   TRANSPARENT = 3'b101
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*WIDTH_X-1:0]   req_x,
   input  logic [NUM_REQ*WIDTH_Y-1:0]   req_y,
   output logic [NUM_REQ-1:0]           done,
   output logic                         busy,
   output logic [WIDTH_SEL-1:0]         sprite_sel,
   output logic [WIDTH_SX-1:0]          sx,
   output logic [WIDTH_SY-1:0]          sy,
   input  logic [2:0]                   rom_color,
   output logic [WIDTH_X-1:0]           vga_x,
   output logic [WIDTH_Y-1:0]           vga_y,
   output logic [2:0]                   vga_color,
   output logic                         vga_plot
);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

   state_t                       state, state_nxt;
   logic [WIDTH_SEL-1:0]         ptr;
   logic [WIDTH_SEL-1:0]         gnt_idx;
   logic                         gnt_any;
   logic [WIDTH_X-1:0]           org_x;
   logic [WIDTH_Y-1:0]           org_y;
   logic [WIDTH_X:0]             px;
   logic [WIDTH_Y:0]             py;
   logic                         vld;
   logic                         last_col, last_row;
   logic [NUM_REQ*WIDTH_X-1:0]   xs;
   logic [NUM_REQ*WIDTH_Y-1:0]   ys;

   // First pending requester at or after p, searching upward with wrap; MSB = found.
   function automatic logic [WIDTH_SEL:0] pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [WIDTH_SEL-1:0] p);
      logic [WIDTH_SEL:0] res;
      logic [NUM_REQ-1:0] sh;
      int                 idx;
      res = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(p) + k) % NUM_REQ;
         sh  = r >> idx;
         if (sh[0]) res = {1'b1, WIDTH_SEL'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      {gnt_any, gnt_idx} = pick(req, ptr);
   end

   assign xs       = req_x >> (int'(gnt_idx) * WIDTH_X);
   assign ys       = req_y >> (int'(gnt_idx) * WIDTH_Y);
   assign last_col = (sx == WIDTH_SX'(SPRITE_W - 1));
   assign last_row = (sy == WIDTH_SY'(SPRITE_H - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_any) state_nxt = SCAN;
         SCAN:    if (last_col && last_row) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         ptr        <= '0;
         sprite_sel <= '0;
         sx         <= '0;
         sy         <= '0;
         org_x      <= '0;
         org_y      <= '0;
         px         <= '0;
         py         <= '0;
         vld        <= 1'b0;
      end else begin
         state <= state_nxt;
         // Valid trails the scan by one cycle, matching the ROM read latency.
         vld   <= (state == SCAN);
         case (state)
            IDLE: begin
               if (gnt_any) begin
                  sprite_sel <= gnt_idx;
                  org_x      <= xs[WIDTH_X-1:0];
                  org_y      <= ys[WIDTH_Y-1:0];
                  sx         <= '0;
                  sy         <= '0;
               end
            end
            SCAN: begin
               px <= (WIDTH_X+1)'(org_x) + (WIDTH_X+1)'(sx);
               py <= (WIDTH_Y+1)'(org_y) + (WIDTH_Y+1)'(sy);
               if (!last_col) begin
                  sx <= sx + 1'b1;
               end else if (!last_row) begin
                  sx <= '0;
                  sy <= sy + 1'b1;
               end
            end
            DONE: begin
               ptr <= (int'(sprite_sel) == NUM_REQ - 1) ? '0 : sprite_sel + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE) ? (NUM_REQ'(1) << sprite_sel) : '0;
   assign vga_x     = px[WIDTH_X-1:0];
   assign vga_y     = py[WIDTH_Y-1:0];
   assign vga_color = rom_color;
   // The extra sum bit keeps off-screen pixels from aliasing back onto the screen.
   assign vga_plot  = vld && (rom_color != TRANSPARENT)
                      && (px < (WIDTH_X+1)'(SCREEN_W))
                      && (py < (WIDTH_Y+1)'(SCREEN_H));

endmodule
